// File: rtl/short_stack_unit.sv
// short_stack_unit
//   Per-ray short stack and restart-state keeper for kd-tree traversal.
//   Sits downstream of the traversal unit's push/pop/update port. It holds up to
//   four deferred far-child nodes per ray, plus the ray's restart node and scene
//   exit distance. On a pop it either returns the next node to the traversal
//   arbiter (tarb) or reports that the ray has left the tree (done).
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   trav_to_ss_*        request in (valid/data) and stall out
//   init_*              new-ray initialisation in (valid/data) and stall out
//   ss_to_tarb_*        next-node output (valid/data) and downstream stall in
//   ss_to_done_*        ray-finished output (valid/data) and downstream stall in
//   pop_hit_cnt, restart_cnt, done_cnt
//                       32-bit saturating event counters; present only when
//                       the macro SS_STATS_EN is defined
//
// Pipeline
//   p0 : request/init registered; it drives RAM read addresses and write ports
//   p1 : RAM read data valid; the result is computed combinationally
//   S2 : output registers (tarb and done are separate registers)
//   The whole pipeline freezes while an S2 output is valid and its stall is high.

package short_stack_unit_pkg;
  localparam int RAY_W  = 6;
  localparam int NODE_W = 32;

  typedef logic [31:0]       float_t;
  typedef logic [NODE_W-1:0] node_id_t;

  typedef struct packed {
    logic [RAY_W-1:0] rayID;
    logic             is_shadow;
    logic [1:0]       ss_wptr;
    logic [2:0]       ss_num;
  } ray_info_t;

  typedef struct packed {
    ray_info_t ray_info;
    logic      push_req;
    logic      update_restnode_req;
    logic      pop_req;
    logic      update_maxscene_req;
    node_id_t  push_node_ID;
    node_id_t  rest_node_ID;
    float_t    t_max;
  } trav_to_ss_t;

  typedef struct packed {
    logic [RAY_W-1:0] rayID;
    float_t           scene_t_max;
  } init_t;

  typedef struct packed {
    ray_info_t ray_info;
    node_id_t  nodeID;
    logic      restnode_search;
    float_t    t_max;
    float_t    t_min;
  } tarb_t;

  typedef struct packed {
    logic [RAY_W-1:0] rayID;
    logic             is_shadow;
  } done_t;

  typedef struct packed {
    node_id_t nodeID;
    float_t   t_max;
  } stk_entry_t;
endpackage

module short_stack_unit
  import short_stack_unit_pkg::*;
#(
  parameter int NUM_RAYS = 64,
  parameter int SS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trav_to_ss_valid,
  input  trav_to_ss_t trav_to_ss_data,
  output logic        trav_to_ss_stall,
  input  logic        init_valid,
  input  init_t       init_data,
  output logic        init_stall,
  output logic        ss_to_tarb_valid,
  output tarb_t       ss_to_tarb_data,
  input  logic        ss_to_tarb_stall,
  output logic        ss_to_done_valid,
  output done_t       ss_to_done_data,
  input  logic        ss_to_done_stall
`ifdef SS_STATS_EN
  ,
  output logic [31:0] pop_hit_cnt,
  output logic [31:0] restart_cnt,
  output logic [31:0] done_cnt
`endif
);

  localparam int STK_AW = RAY_W + 2;

  // Non-negative IEEE floats order the same as their unsigned bit patterns.
  function automatic logic float_ge(input float_t a, input float_t b);
    return a >= b;
  endfunction

  logic frozen;

  // p0 registers
  logic        trav_vld_p0_q;
  logic        init_vld_p0_q;
  trav_to_ss_t req_p0_q;
  init_t       init_p0_q;

  // p1 registers (RAM read data included)
  logic        vld_p1_q;
  ray_info_t   ray_info_p1_q;
  logic        pop_p1_q;
  float_t      tmin_p1_q;
  stk_entry_t  stk_rd_p1_q;
  node_id_t    rn_rd_p1_q;
  float_t      sc_rd_p1_q;

  // S2 registers
  logic        tarb_vld_q;
  tarb_t       tarb_q;
  logic        done_vld_q;
  done_t       done_q;

  // Storage: never reset, contents survive a reset.
  stk_entry_t  stk_mem [NUM_RAYS*SS_DEPTH];
  node_id_t    rn_mem  [NUM_RAYS];
  float_t      sc_mem  [NUM_RAYS];

  logic [STK_AW-1:0] stk_waddr;
  logic [STK_AW-1:0] stk_raddr;
  logic [1:0]        rd_wptr;
  logic              stk_we;
  stk_entry_t        stk_wdata;
  logic              rn_we;
  logic [RAY_W-1:0]  rn_waddr;
  node_id_t          rn_wdata;
  logic              sc_we;
  logic [RAY_W-1:0]  sc_waddr;
  float_t            sc_wdata;

  logic  tarb_vld_d;
  tarb_t tarb_d;
  logic  done_vld_d;
  done_t done_d;
  logic  stk_hit;
  logic  reached_exit;

  // Only an output that actually holds a result can back-pressure the pipe.
  assign frozen           = (tarb_vld_q & ss_to_tarb_stall) | (done_vld_q & ss_to_done_stall);
  assign trav_to_ss_stall = frozen;
  assign init_stall       = trav_to_ss_valid | frozen;

  assign ss_to_tarb_valid = tarb_vld_q;
  assign ss_to_tarb_data  = tarb_q;
  assign ss_to_done_valid = done_vld_q;
  assign ss_to_done_data  = done_q;

  // ---- p0: accept request or init (trav wins) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trav_vld_p0_q <= 1'b0;
      init_vld_p0_q <= 1'b0;
    end else if (!frozen) begin
      trav_vld_p0_q <= trav_to_ss_valid;
      init_vld_p0_q <= init_valid & ~trav_to_ss_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!frozen) begin
      if (trav_to_ss_valid) req_p0_q <= trav_to_ss_data;
      if (init_valid)       init_p0_q <= init_data;
    end
  end

  // Write and read ports are driven from p0. The incoming ss_wptr is the
  // pre-increment slot for a push; a pop reads the slot just below it.
  always_comb begin
    rd_wptr   = req_p0_q.ray_info.ss_wptr - 2'd1;
    stk_raddr = {req_p0_q.ray_info.rayID, rd_wptr};
    stk_waddr = {req_p0_q.ray_info.rayID, req_p0_q.ray_info.ss_wptr};
    stk_we    = trav_vld_p0_q & req_p0_q.push_req;
    stk_wdata = '{nodeID: req_p0_q.push_node_ID, t_max: req_p0_q.t_max};

    rn_we     = (trav_vld_p0_q & req_p0_q.update_restnode_req) | init_vld_p0_q;
    rn_waddr  = init_vld_p0_q ? init_p0_q.rayID : req_p0_q.ray_info.rayID;
    rn_wdata  = init_vld_p0_q ? '0 : req_p0_q.rest_node_ID;

    sc_we     = (trav_vld_p0_q & req_p0_q.update_maxscene_req) | init_vld_p0_q;
    sc_waddr  = init_vld_p0_q ? init_p0_q.rayID : req_p0_q.ray_info.rayID;
    sc_wdata  = init_vld_p0_q ? init_p0_q.scene_t_max : req_p0_q.t_max;
  end

  // ---- p0 -> p1: RAM write commit and synchronous read ----
  always_ff @(posedge clk) begin
    if (!frozen) begin
      if (stk_we) stk_mem[stk_waddr] <= stk_wdata;
      if (rn_we)  rn_mem[rn_waddr]   <= rn_wdata;
      if (sc_we)  sc_mem[sc_waddr]   <= sc_wdata;
      stk_rd_p1_q <= stk_mem[stk_raddr];
      rn_rd_p1_q  <= rn_mem[req_p0_q.ray_info.rayID];
      sc_rd_p1_q  <= sc_mem[req_p0_q.ray_info.rayID];
      if (trav_vld_p0_q) begin
        ray_info_p1_q <= req_p0_q.ray_info;
        pop_p1_q      <= req_p0_q.pop_req;
        tmin_p1_q     <= req_p0_q.t_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
    end else if (!frozen) begin
      vld_p1_q <= trav_vld_p0_q;
    end
  end

  // ---- p1: pop resolution ----
  always_comb begin
    stk_hit      = ray_info_p1_q.ss_num != 3'd0;
    reached_exit = float_ge(tmin_p1_q, sc_rd_p1_q);

    tarb_d          = '0;
    tarb_d.ray_info = ray_info_p1_q;
    tarb_d.t_min    = tmin_p1_q;
    if (stk_hit) begin
      tarb_d.nodeID           = stk_rd_p1_q.nodeID;
      tarb_d.t_max            = stk_rd_p1_q.t_max;
      tarb_d.ray_info.ss_wptr = ray_info_p1_q.ss_wptr - 2'd1;
      tarb_d.ray_info.ss_num  = ray_info_p1_q.ss_num - 3'd1;
      tarb_d.restnode_search  = 1'b0;
    end else begin
      // Stack empty: restart from the stored restart node up to scene exit.
      tarb_d.nodeID           = rn_rd_p1_q;
      tarb_d.t_max            = sc_rd_p1_q;
      tarb_d.ray_info.ss_num  = 3'd0;
      tarb_d.restnode_search  = 1'b1;
    end

    done_d           = '0;
    done_d.rayID     = ray_info_p1_q.rayID;
    done_d.is_shadow = ray_info_p1_q.is_shadow;

    tarb_vld_d = vld_p1_q & pop_p1_q & (stk_hit | ~reached_exit);
    done_vld_d = vld_p1_q & pop_p1_q & ~stk_hit & reached_exit;
  end

  // ---- S2: output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tarb_vld_q <= 1'b0;
      tarb_q     <= '0;
      done_vld_q <= 1'b0;
      done_q     <= '0;
    end else if (!frozen) begin
      tarb_vld_q <= tarb_vld_d;
      done_vld_q <= done_vld_d;
      if (tarb_vld_d) tarb_q <= tarb_d;
      if (done_vld_d) done_q <= done_d;
    end
  end

`ifdef SS_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_hit_cnt <= '0;
      restart_cnt <= '0;
      done_cnt    <= '0;
    end else if (!frozen) begin
      if (tarb_vld_d && stk_hit)  pop_hit_cnt <= sat_inc(pop_hit_cnt);
      if (tarb_vld_d && !stk_hit) restart_cnt <= sat_inc(restart_cnt);
      if (done_vld_d)             done_cnt    <= sat_inc(done_cnt);
    end
  end
`endif

`ifndef SYNTH
  // No forwarding exists, so a ray may occupy only one of p1 / S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(vld_p1_q &&
                ((tarb_vld_q && tarb_q.ray_info.rayID == ray_info_p1_q.rayID) ||
                 (done_vld_q && done_q.rayID == ray_info_p1_q.rayID))))
        else $error("short_stack_unit: rayID %0d present in p1 and S2", ray_info_p1_q.rayID);
    end
  end
`endif

endmodule

// File: tb/tb_short_stack_unit.sv
module tb_short_stack_unit;
  import short_stack_unit_pkg::*;

  localparam float_t F3  = 32'h4040_0000;
  localparam float_t F4  = 32'h4080_0000;
  localparam float_t F8  = 32'h4100_0000;
  localparam float_t F10 = 32'h4120_0000;
  localparam float_t F20 = 32'h41A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        trav_to_ss_valid;
  trav_to_ss_t trav_to_ss_data;
  logic        trav_to_ss_stall;
  logic        init_valid;
  init_t       init_data;
  logic        init_stall;
  logic        ss_to_tarb_valid;
  tarb_t       ss_to_tarb_data;
  logic        ss_to_tarb_stall;
  logic        ss_to_done_valid;
  done_t       ss_to_done_data;
  logic        ss_to_done_stall;
`ifdef SS_STATS_EN
  logic [31:0] pop_hit_cnt, restart_cnt, done_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  short_stack_unit dut (
    .clk              (clk),
    .rst              (rst),
    .trav_to_ss_valid (trav_to_ss_valid),
    .trav_to_ss_data  (trav_to_ss_data),
    .trav_to_ss_stall (trav_to_ss_stall),
    .init_valid       (init_valid),
    .init_data        (init_data),
    .init_stall       (init_stall),
    .ss_to_tarb_valid (ss_to_tarb_valid),
    .ss_to_tarb_data  (ss_to_tarb_data),
    .ss_to_tarb_stall (ss_to_tarb_stall),
    .ss_to_done_valid (ss_to_done_valid),
    .ss_to_done_data  (ss_to_done_data),
    .ss_to_done_stall (ss_to_done_stall)
`ifdef SS_STATS_EN
    ,
    .pop_hit_cnt      (pop_hit_cnt),
    .restart_cnt      (restart_cnt),
    .done_cnt         (done_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic trav_to_ss_t mk_req(input logic [5:0] ray, input logic shadow,
                                         input logic [1:0] wptr, input logic [2:0] num,
                                         input logic push, input logic updrn,
                                         input logic pop, input logic updms,
                                         input node_id_t pnode, input node_id_t rnode,
                                         input float_t tmax);
    trav_to_ss_t r;
    r = '0;
    r.ray_info.rayID     = ray;
    r.ray_info.is_shadow = shadow;
    r.ray_info.ss_wptr   = wptr;
    r.ray_info.ss_num    = num;
    r.push_req            = push;
    r.update_restnode_req = updrn;
    r.pop_req             = pop;
    r.update_maxscene_req = updms;
    r.push_node_ID        = pnode;
    r.rest_node_ID        = rnode;
    r.t_max               = tmax;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input trav_to_ss_t r);
    int g;
    g = 0;
    trav_to_ss_valid = 1'b1;
    trav_to_ss_data  = r;
    while (trav_to_ss_stall && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("send_accept", 64'(trav_to_ss_stall), 64'(1'b0));
    @(negedge clk);
    trav_to_ss_valid = 1'b0;
  endtask

  task automatic do_init(input logic [5:0] ray, input float_t st);
    init_valid = 1'b1;
    init_data  = '{rayID: ray, scene_t_max: st};
    @(negedge clk);
    init_valid = 1'b0;
  endtask

  task automatic wait_out(output logic got_t, output logic got_d);
    int n;
    n = 0;
    while (!ss_to_tarb_valid && !ss_to_done_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    got_t = ss_to_tarb_valid;
    got_d = ss_to_done_valid;
    chk("out_arrived", 64'(got_t | got_d), 64'(1'b1));
  endtask

  task automatic chk_tarb(input string tag, input logic [5:0] ray, input node_id_t node,
                          input float_t tmin, input float_t tmax, input logic [1:0] wp,
                          input logic [2:0] num, input logic rs);
    chk({tag, "_vld"},  64'(ss_to_tarb_valid), 64'(1'b1));
    chk({tag, "_ray"},  64'(ss_to_tarb_data.ray_info.rayID), 64'(ray));
    chk({tag, "_node"}, 64'(ss_to_tarb_data.nodeID), 64'(node));
    chk({tag, "_tmin"}, 64'(ss_to_tarb_data.t_min), 64'(tmin));
    chk({tag, "_tmax"}, 64'(ss_to_tarb_data.t_max), 64'(tmax));
    chk({tag, "_wptr"}, 64'(ss_to_tarb_data.ray_info.ss_wptr), 64'(wp));
    chk({tag, "_num"},  64'(ss_to_tarb_data.ray_info.ss_num), 64'(num));
    chk({tag, "_rs"},   64'(ss_to_tarb_data.restnode_search), 64'(rs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic gt, gd;
    logic [1:0] pop_wp [4];
    logic [2:0] pop_num [4];
    node_id_t   got_nodes [4];
    int cnt;

    rst = 1'b0;
    trav_to_ss_valid = 1'b0;
    trav_to_ss_data  = '0;
    init_valid       = 1'b0;
    init_data        = '0;
    ss_to_tarb_stall = 1'b0;
    ss_to_done_stall = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tarb_vld",  64'(ss_to_tarb_valid), 64'(1'b0));
    chk("rst_done_vld",  64'(ss_to_done_valid), 64'(1'b0));
    chk("rst_tarb_data", 64'(ss_to_tarb_data.nodeID), 64'(0));
    chk("rst_done_data", 64'(ss_to_done_data), 64'(0));
    chk("rst_trav_stall", 64'(trav_to_ss_stall), 64'(1'b0));
    chk("rst_init_stall", 64'(init_stall), 64'(1'b0));
    rst = 1'b1;
    @(negedge clk);

    do_init(6'd5, F10);
    do_init(6'd7, F20);
    for (int r = 10; r < 14; r++) do_init(6'(r), F10);
    do_init(6'd20, F10);
    do_init(6'd21, F10);

    // push node 0x22 with restart node 0x11; init must be blocked meanwhile
    trav_to_ss_valid = 1'b1;
    trav_to_ss_data  = mk_req(6'd5, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 32'h11, F8);
    #1 chk("init_stall_prio", 64'(init_stall), 64'(1'b1));
    @(negedge clk);
    trav_to_ss_valid = 1'b0;

    // pop hit with exact latency
    send(mk_req(6'd5, 1'b0, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F3));
    chk("lat_n0", 64'(ss_to_tarb_valid), 64'(1'b0));
    @(negedge clk);
    chk("lat_n1", 64'(ss_to_tarb_valid), 64'(1'b0));
    @(negedge clk);
    chk_tarb("pop5", 6'd5, 32'h22, F3, F8, 2'd0, 3'd0, 1'b0);
    chk("pop5_done", 64'(ss_to_done_valid), 64'(1'b0));
    @(negedge clk);
    chk("pop5_once", 64'(ss_to_tarb_valid), 64'(1'b0));

    // empty stack, before scene exit -> restart
    send(mk_req(6'd5, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F4));
    wait_out(gt, gd);
    chk("restart5_done", 64'(gd), 64'(1'b0));
    chk_tarb("restart5", 6'd5, 32'h11, F4, F10, 2'd0, 3'd0, 1'b1);
    @(negedge clk);

    // empty stack at scene exit -> done
    send(mk_req(6'd5, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F10));
    wait_out(gt, gd);
    chk("exit5_tarb", 64'(gt), 64'(1'b0));
    chk("exit5_done", 64'(gd), 64'(1'b1));
    chk("exit5_ray", 64'(ss_to_done_data.rayID), 64'(6'd5));
    chk("exit5_shadow", 64'(ss_to_done_data.is_shadow), 64'(1'b1));
    @(negedge clk);

    // move scene exit to 20.0, then the same pop restarts
    send(mk_req(6'd5, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, F20));
    send(mk_req(6'd5, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F10));
    wait_out(gt, gd);
    chk_tarb("maxscene5", 6'd5, 32'h11, F10, F20, 2'd0, 3'd0, 1'b1);
    @(negedge clk);

    // five pushes overflow the four-entry stack of ray 7
    for (int k = 0; k < 5; k++)
      send(mk_req(6'd7, 1'b0, 2'(k), 3'((k < 4) ? k : 4), 1'b1, 1'b0, 1'b0, 1'b0,
                  32'(k + 1), 32'h0, 32'h3F80_0000 + 32'(k + 1)));
    pop_wp  = '{2'd1, 2'd0, 2'd3, 2'd2};
    pop_num = '{3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 4; k++) begin
      send(mk_req(6'd7, 1'b0, pop_wp[k], pop_num[k], 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
      wait_out(gt, gd);
      chk_tarb($sformatf("ovf_pop%0d", k), 6'd7, 32'(5 - k), 32'h0,
               32'h3F80_0000 + 32'(5 - k), pop_wp[k] - 2'd1, pop_num[k] - 3'd1, 1'b0);
      @(negedge clk);
    end
    send(mk_req(6'd7, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
    wait_out(gt, gd);
    chk_tarb("ovf_empty", 6'd7, 32'h0, 32'h0, F20, 2'd1, 3'd0, 1'b1);
    @(negedge clk);

    // tarb stall with back-to-back pops on rays 10..13
    for (int r = 10; r < 14; r++)
      send(mk_req(6'(r), 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(r), 32'h0, F8));
    ss_to_tarb_stall = 1'b1;
    chk("stall_no_out", 64'(trav_to_ss_stall), 64'(1'b0));
    for (int i = 0; i < 4; i++) begin
      trav_to_ss_valid = 1'b1;
      trav_to_ss_data  = mk_req(6'(10 + i), 1'b0, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0,
                                32'h0, 32'h0, 32'h0);
      if (i < 3) @(negedge clk);
    end
    chk("hold_stall0", 64'(trav_to_ss_stall), 64'(1'b1));
    chk("hold_node0", 64'(ss_to_tarb_data.nodeID), 64'(32'h10A));
    for (int h = 1; h < 4; h++) begin
      @(negedge clk);
      chk($sformatf("hold_stall%0d", h), 64'(trav_to_ss_stall), 64'(1'b1));
      chk($sformatf("hold_vld%0d", h), 64'(ss_to_tarb_valid), 64'(1'b1));
      chk($sformatf("hold_node%0d", h), 64'(ss_to_tarb_data.nodeID), 64'(32'h10A));
    end
    ss_to_tarb_stall = 1'b0;
    @(negedge clk);
    trav_to_ss_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (ss_to_tarb_valid) begin
        if (cnt < 4) got_nodes[cnt] = ss_to_tarb_data.nodeID;
        cnt++;
      end
      @(negedge clk);
    end
    chk("drain_count", 64'(cnt), 64'(3));
    for (int i = 0; i < 3; i++)
      chk($sformatf("drain_node%0d", i), 64'(got_nodes[i]), 64'(32'h10B + 32'(i)));

    // done stall freezes the pipe; an idle stalled tarb does not
    ss_to_done_stall = 1'b1;
    ss_to_tarb_stall = 1'b1;
    send(mk_req(6'd5, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F20));
    wait_out(gt, gd);
    chk("dstall_done", 64'(gd), 64'(1'b1));
    @(negedge clk);
    chk("dstall_frozen", 64'(trav_to_ss_stall), 64'(1'b1));
    chk("dstall_held", 64'(ss_to_done_valid), 64'(1'b1));
    chk("dstall_ray", 64'(ss_to_done_data.rayID), 64'(6'd5));
    ss_to_done_stall = 1'b0;
    @(negedge clk);
    chk("dstall_clear", 64'(ss_to_done_valid), 64'(1'b0));
    chk("dstall_unfrozen", 64'(trav_to_ss_stall), 64'(1'b0));
    ss_to_tarb_stall = 1'b0;

    // reset in the middle of a pop stream
    send(mk_req(6'd20, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, F8));
    send(mk_req(6'd21, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h210, 32'h0, F8));
    send(mk_req(6'd20, 1'b0, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
    send(mk_req(6'd21, 1'b0, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    chk("mid_vld", 64'(ss_to_tarb_valid), 64'(1'b1));
    rst = 1'b0;
    #1;
    chk("mid_rst_tarb", 64'(ss_to_tarb_valid), 64'(1'b0));
    chk("mid_rst_done", 64'(ss_to_done_valid), 64'(1'b0));
    chk("mid_rst_data", 64'(ss_to_tarb_data.nodeID), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ss_to_tarb_valid || ss_to_done_valid) cnt++;
    end
    chk("mid_dropped", 64'(cnt), 64'(0));
    do_init(6'd21, F10);
    send(mk_req(6'd21, 1'b0, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F3));
    wait_out(gt, gd);
    chk_tarb("post_rst", 6'd21, 32'h210, F3, F8, 2'd0, 3'd0, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/short_stack_unit.md
# short_stack_unit

Per-ray short-stack and restart-state keeper for kd-tree traversal. Sits directly downstream of the traversal unit's push/pop/update port. Stores up to four deferred far-child nodes per ray plus each ray's restart node and scene exit distance. On a pop it feeds the next node back to the traversal arbiter, or reports the ray as finished with the tree.

## Interface
- NUM_RAYS, 64: rays in flight; rayID width = $clog2(NUM_RAYS).
- SS_DEPTH, 4: fixed short-stack depth; ss_wptr is 2 bits, ss_num is 3 bits. Other values are unsupported.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- trav_to_ss_valid  in  1  request valid.
- trav_to_ss_data  in  trav_to_ss_t  request fields:
  - ray_info: rayID, is_shadow, ss_wptr, ss_num.
  - Flags: push_req, update_restnode_req, pop_req, update_maxscene_req.
  - push_node_ID, rest_node_ID, t_max.
- trav_to_ss_stall  out  1  request not accepted this cycle.
- init_valid  in  1  new-ray initialisation valid.
- init_data  in  {rayID, float_t scene_t_max}  new-ray initialisation payload.
- init_stall  out  1  initialisation not accepted this cycle.
- ss_to_tarb_valid  out  1  next-node output valid.
- ss_to_tarb_data  out  tarb_t  next node: ray_info, nodeID, restnode_search, t_max, t_min.
- ss_to_tarb_stall  in  1  downstream stall for next-node output.
- ss_to_done_valid  out  1  ray-exited-tree output valid.
- ss_to_done_data  out  {rayID, is_shadow}  ray-exited-tree payload.
- ss_to_done_stall  in  1  downstream stall for ray-exited-tree output.

## Operation
- Per-ray storage:
  - stack[rayID][0..3] = {nodeID, t_max}.
  - restnode[rayID].
  - scene_tmax[rayID].
- All three arrays use synchronous read, one write port each. None are cleared by reset.
- Init port: writes restnode = 0 and scene_tmax = scene_t_max.
  - A trav request has priority over init.
  - init_stall = trav_to_ss_valid | pipeline stalled.
- Request flags are processed together in one pass. Legal combinations are push+update_restnode, pop alone, and update_maxscene alone.
- push_req: write {push_node_ID, t_max} into stack[rayID][ss_wptr]. The incoming ss_wptr is the pre-increment value. No output.
- update_restnode_req: restnode[rayID] = rest_node_ID.
- update_maxscene_req: scene_tmax[rayID] = t_max. No output.
- pop_req with ss_num != 0: read entry e = stack[rayID][ss_wptr-1 mod 4] and emit to tarb:
  - nodeID = e.nodeID.
  - t_min = req.t_max.
  - t_max = e.t_max.
  - ss_wptr = ss_wptr-1 mod 4.
  - ss_num = ss_num-1.
  - restnode_search = 0.
- pop_req with ss_num == 0, comparing req.t_max against scene_tmax:
  - Floats are non-negative, so they compare as unsigned 32-bit values.
  - If req.t_max >= scene_tmax: emit to done.
  - Otherwise emit a restart to tarb:
    - nodeID = restnode.
    - t_min = req.t_max.
    - t_max = scene_tmax.
    - restnode_search = 1.
    - ss_num = 0.
    - ss_wptr unchanged.
- Precondition: at most one request per rayID is in the pipeline at a time. This holds because a ray lives in exactly one pipeline location.
  - No forwarding is provided.
  - In non-SYNTH builds, an assertion fires if stage 1 and stage 2 hold the same rayID.
- Same-cycle write and read to different rays: the read returns the old data of its own ray. No conflict arises.

## Timing
- Three-stage pipeline:
  - S0: accept request and drive read addresses.
  - S1: RAM data valid; compute result.
  - S2: output registers.
- Latency: a request accepted at edge N appears on the tarb/done valid after edge N+2.
- Writes commit at the edge that accepts the request into S1.
- Throughput: one request per cycle when neither output is stalled.
- Stall rule: the pipeline freezes when S2 holds a valid output whose stall is high.
  - trav_to_ss_stall = frozen.
  - The tarb and done outputs are separate registers. Only the one carrying a valid result stalls the pipeline.
- Outputs are held stable while valid and stalled.
- Reset values:
  - All valids 0 and all data 0.
  - trav_to_ss_stall = 0 and init_stall = 0.
- Reset mid-operation drops in-flight requests. Array contents survive but must be re-initialised.
- Boundary cases:
  - A pop with ss_wptr = 0 reads entry 3.
  - A push with ss_num = 4 overwrites the oldest entry. This is expected short-stack behaviour.

## Configuration
- SS_STATS_EN defined: adds output ports pop_hit_cnt, restart_cnt and done_cnt, each 32 bits.
  - Each increments by 1 when its output type enters S2.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- SS_STATS_EN undefined: these ports and counters are absent.

## Test plan
- Init ray 5 with scene_tmax = 10.0. Push node 0x22 (t_max = 8.0, wptr = 0), then pop with wptr = 1, num = 1, t_max = 3.0 -> tarb output at N+2 with nodeID 0x22, t_min 3.0, t_max 8.0, wptr 0, num 0, restnode_search 0.
- Ray 5 pop with num = 0, t_max = 4.0, after update_restnode = 0x11 -> tarb nodeID 0x11, t_min 4.0, t_max 10.0, restnode_search 1.
- Ray 5 pop with num = 0, t_max = 10.0 -> done output {5, is_shadow}; no tarb output.
- Five pushes to ray 7 (wptr 0,1,2,3,0; nodes 1..5), then pops at wptr 1,0,3,2 -> nodes 5,4,3,2; node 1 lost.
- Hold ss_to_tarb_stall for 3 cycles with a valid output and back-to-back pops queued:
  - trav_to_ss_stall is high during the hold.
  - Outputs stay stable.
  - No request is lost or duplicated.
- Assert rst during a stream of pops -> all valids 0 immediately; traffic after release is processed correctly.
